// File: rtl/md5_pkg.sv
// Shared constants and types for the md5 digest-match stages.
// The word-slice offsets are also used by the md5core benches.
package md5_pkg;

    localparam int MSG_W  = 152;
    localparam int HASH_W = 128;
    localparam int WORD_W = 32;

    // LSB of each digest word inside a packed {A,B,C,D} hash.
    localparam int A_LSB = 96;
    localparam int B_LSB = 64;
    localparam int C_LSB = 32;
    localparam int D_LSB = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEARCH    = 2'd1,
        FOUND     = 2'd2,
        EXHAUSTED = 2'd3
    } state_e;

endpackage

// File: rtl/md5_hash_cmp.sv
// Registered per-word digest compare; the final AND of the four word
// matches is left for the consumer so the 128-bit equality is split in two.
module md5_hash_cmp #(
    parameter int MSG_W = md5_pkg::MSG_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [md5_pkg::HASH_W-1:0] target,
    input  logic [md5_pkg::HASH_W-1:0] digest,
    input  logic [MSG_W-1:0]           message,
    input  logic                       valid,
    output logic                       hit,
    output logic [MSG_W-1:0]           mesg_s1,
    output logic                       valid_s1
);
    import md5_pkg::*;

    logic [3:0]       eq_d, eq_q;
    logic [MSG_W-1:0] mesg_d, mesg_q;
    logic             valid_d, valid_q;

    always_comb begin
        eq_d    = eq_q;
        mesg_d  = mesg_q;
        valid_d = valid;
        if (valid) begin
            eq_d[3] = digest[A_LSB +: WORD_W] == target[A_LSB +: WORD_W];
            eq_d[2] = digest[B_LSB +: WORD_W] == target[B_LSB +: WORD_W];
            eq_d[1] = digest[C_LSB +: WORD_W] == target[C_LSB +: WORD_W];
            eq_d[0] = digest[D_LSB +: WORD_W] == target[D_LSB +: WORD_W];
            mesg_d  = message;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eq_q    <= '0;
            mesg_q  <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            eq_q    <= eq_d;
            mesg_q  <= mesg_d;
            valid_q <= valid_d;
        end
    end

    assign hit      = valid_q & (&eq_q);
    assign mesg_s1  = mesg_q;
    assign valid_s1 = valid_q;

endmodule

// File: rtl/md5_match_filter.sv
// Search controller behind md5core: counts examined digests, latches the
// first message whose digest equals target_hash, reports FOUND/EXHAUSTED.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no search armed; pipeline results are discarded
// SEARCH    | counting valid results, waiting for a hit or the limit
// FOUND     | match latched in match_mesg; further results ignored
// EXHAUSTED | count_limit results seen without a hit
module md5_match_filter #(
    parameter int MSG_W = md5_pkg::MSG_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             start,
    input  logic             abort,
    input  logic [127:0]     target_hash,
    input  logic [CNT_W-1:0] count_limit,
    input  logic [31:0]      a_in,
    input  logic [31:0]      b_in,
    input  logic [31:0]      c_in,
    input  logic [31:0]      d_in,
    input  logic [MSG_W-1:0] m_in,
    input  logic             valid_in,
    output logic             busy,
    output logic             done,
    output logic             match_found,
    output logic [MSG_W-1:0] match_mesg,
    output logic [CNT_W-1:0] hash_count
);
    import md5_pkg::*;

    logic             hit;
    logic [MSG_W-1:0] mesg_s1;
    logic             valid_s1;

    md5_hash_cmp #(.MSG_W(MSG_W)) u_cmp (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .target   (target_hash),
        .digest   ({a_in, b_in, c_in, d_in}),
        .message  (m_in),
        .valid    (valid_in),
        .hit      (hit),
        .mesg_s1  (mesg_s1),
        .valid_s1 (valid_s1)
    );

    state_e           state_d, state_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic [CNT_W-1:0] count_inc;
    logic [MSG_W-1:0] mesg_d, mesg_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             found_d, found_q;

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mesg_d  = mesg_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, FOUND, EXHAUSTED: begin
                    if (start) begin
                        state_d = SEARCH;
                        count_d = '0;
                        mesg_d  = '0;
                    end
                end
                SEARCH: begin
                    if (valid_s1) begin
                        if (!(&count_q))
                            count_d = count_inc;
                        // A hit outranks reaching the limit on the same result.
                        if (hit) begin
                            state_d = FOUND;
                            mesg_d  = mesg_s1;
                        end else if (count_limit != '0 && count_inc == count_limit) begin
                            state_d = EXHAUSTED;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d  = (state_d == SEARCH);
        done_d  = (state_d == FOUND) || (state_d == EXHAUSTED);
        found_d = (state_d == FOUND);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            mesg_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            count_q <= count_d;
            mesg_q  <= mesg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign match_found = found_q;
    assign match_mesg  = mesg_q;
    assign hash_count  = count_q;

endmodule

// File: tb/tb_md5_match_filter.sv
// Self-checking bench for md5_match_filter: vector table with a due-cycle
// scoreboard, plus hand sequences for stall, abort, restart and reset.
module tb_md5_match_filter;

    localparam logic [127:0] T    = 128'ha2004f37_730b9445_670a738f_a0fc9ee5;
    localparam logic [127:0] NEAR = 128'ha2004f37_730b9445_670a738f_a0fc9ee4;
    localparam logic [127:0] NM1  = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] NM2  = 128'h11111111_22222222_33333333_44444444;
    localparam logic [151:0] FOX  = 152'h54686520_71756963_6b206272_6f776e20_666f78;
    localparam logic [151:0] M3   = 152'h33333333_44444444_55555555_66666666_777777;
    localparam logic [151:0] M5   = 152'hdeadbeef_cafef00d_01020304_05060708_090a0b;
    localparam logic [151:0] MX   = 152'h0badf00d_0badf00d_0badf00d_0badf00d_0badf0;

    logic         clk = 1'b0;
    logic         reset_n, en, start, abort, valid_in;
    logic [127:0] target_hash;
    logic [31:0]  count_limit;
    logic [31:0]  a_in, b_in, c_in, d_in;
    logic [151:0] m_in;
    logic         busy, done, match_found;
    logic [151:0] match_mesg;
    logic [31:0]  hash_count;

    md5_match_filter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .start       (start),
        .abort       (abort),
        .target_hash (target_hash),
        .count_limit (count_limit),
        .a_in        (a_in),
        .b_in        (b_in),
        .c_in        (c_in),
        .d_in        (d_in),
        .m_in        (m_in),
        .valid_in    (valid_in),
        .busy        (busy),
        .done        (done),
        .match_found (match_found),
        .match_mesg  (match_mesg),
        .hash_count  (hash_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           grp;
        logic [31:0]  lim;
        logic [127:0] dig;
        logic [151:0] m;
        logic         ebusy;
        logic         edone;
        logic         efound;
        logic [31:0]  ecnt;
        logic [151:0] emesg;
    } vec_t;

    typedef struct {
        int           due;
        int           idx;
        logic         ebusy;
        logic         edone;
        logic         efound;
        logic [31:0]  ecnt;
        logic [151:0] emesg;
    } exp_t;

    vec_t vt[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [151:0] act, input logic [151:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check($sformatf("v%0d busy", e.idx), busy, e.ebusy);
            check($sformatf("v%0d done", e.idx), done, e.edone);
            check($sformatf("v%0d match_found", e.idx), match_found, e.efound);
            check($sformatf("v%0d hash_count", e.idx), hash_count, e.ecnt);
            check($sformatf("v%0d match_mesg", e.idx), match_mesg, e.emesg);
        end
    endtask

    task automatic drive(input logic [127:0] dig, input logic [151:0] m, input logic v);
        {a_in, b_in, c_in, d_in} = dig;
        m_in     = m;
        valid_in = v;
    endtask

    task automatic arm(input logic [31:0] lim);
        drive('0, '0, 1'b0);
        count_limit = lim;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start busy", busy, 1'b1);
        check("start clears count", hash_count, 32'd0);
        check("start clears mesg", match_mesg, 152'd0);
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        int prev;
        exp_t e;

        vt.push_back('{1, 32'd0, NM1,  MX,  1'b1, 1'b0, 1'b0, 32'd1, 152'd0});
        vt.push_back('{1, 32'd0, T,    FOX, 1'b0, 1'b1, 1'b1, 32'd2, FOX});
        vt.push_back('{1, 32'd0, NM2,  MX,  1'b0, 1'b1, 1'b1, 32'd2, FOX});
        vt.push_back('{2, 32'd5, NM1,  MX,  1'b1, 1'b0, 1'b0, 32'd1, 152'd0});
        vt.push_back('{2, 32'd5, NM2,  MX,  1'b1, 1'b0, 1'b0, 32'd2, 152'd0});
        vt.push_back('{2, 32'd5, NM1,  MX,  1'b1, 1'b0, 1'b0, 32'd3, 152'd0});
        vt.push_back('{2, 32'd5, NEAR, MX,  1'b1, 1'b0, 1'b0, 32'd4, 152'd0});
        vt.push_back('{2, 32'd5, NM2,  MX,  1'b0, 1'b1, 1'b0, 32'd5, 152'd0});
        vt.push_back('{2, 32'd5, T,    MX,  1'b0, 1'b1, 1'b0, 32'd5, 152'd0});
        vt.push_back('{3, 32'd3, NM1,  MX,  1'b1, 1'b0, 1'b0, 32'd1, 152'd0});
        vt.push_back('{3, 32'd3, NM2,  MX,  1'b1, 1'b0, 1'b0, 32'd2, 152'd0});
        vt.push_back('{3, 32'd3, T,    M3,  1'b0, 1'b1, 1'b1, 32'd3, M3});
        vt.push_back('{4, 32'd0, NEAR, MX,  1'b1, 1'b0, 1'b0, 32'd1, 152'd0});
        vt.push_back('{4, 32'd0, NM1,  MX,  1'b1, 1'b0, 1'b0, 32'd2, 152'd0});

        reset_n = 1'b0;
        en = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        target_hash = T;
        count_limit = '0;
        drive('0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset match_found", match_found, 1'b0);
        check("reset match_mesg", match_mesg, 152'd0);
        check("reset hash_count", hash_count, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        prev = -1;
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].grp != prev) begin
                drive('0, '0, 1'b0);
                tick();
                tick();
                pulse_abort();
                tick();
                arm(vt[i].lim);
                prev = vt[i].grp;
            end
            drive(vt[i].dig, vt[i].m, 1'b1);
            e = '{cyc + 2, i, vt[i].ebusy, vt[i].edone, vt[i].efound, vt[i].ecnt, vt[i].emesg};
            exp_q.push_back(e);
            tick();
        end
        drive('0, '0, 1'b0);
        repeat (3) tick();
        check("scoreboard drained", 152'(exp_q.size()), 152'd0);

        // start while searching must not restart the count
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start in SEARCH ignored count", hash_count, 32'd2);
        check("start in SEARCH ignored busy", busy, 1'b1);

        // en low between stage 1 capture and the decision
        pulse_abort();
        tick();
        arm(32'd0);
        drive(T, M5, 1'b1);
        tick();
        drive('0, '0, 1'b0);
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("stall%0d match_found", k), match_found, 1'b0);
            check($sformatf("stall%0d busy", k), busy, 1'b1);
        end
        en = 1'b1;
        tick();
        check("after stall match_found", match_found, 1'b1);
        check("after stall done", done, 1'b1);
        check("after stall match_mesg", match_mesg, M5);
        check("after stall hash_count", hash_count, 32'd1);
        pulse_abort();
        check("abort FOUND done", done, 1'b0);
        check("abort FOUND match_found", match_found, 1'b0);
        check("abort FOUND busy", busy, 1'b0);
        check("abort keeps match_mesg", match_mesg, M5);
        check("abort keeps hash_count", hash_count, 32'd1);

        // abort on the same edge as a hit wins
        tick();
        arm(32'd0);
        drive(T, MX, 1'b1);
        tick();
        drive('0, '0, 1'b0);
        pulse_abort();
        check("abort vs hit match_found", match_found, 1'b0);
        check("abort vs hit done", done, 1'b0);
        check("abort vs hit mesg", match_mesg, 152'd0);

        // asynchronous reset mid-search
        tick();
        arm(32'd0);
        drive(NM1, MX, 1'b1);
        tick();
        drive(NM2, MX, 1'b1);
        tick();
        drive('0, '0, 1'b0);
        tick();
        check("pre-reset hash_count", hash_count, 32'd2);
        #3;
        reset_n = 1'b0;
        #1;
        check("async reset busy", busy, 1'b0);
        check("async reset done", done, 1'b0);
        check("async reset hash_count", hash_count, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(T, FOX, 1'b1);
        tick();
        drive('0, '0, 1'b0);
        tick();
        tick();
        check("idle valid not counted", hash_count, 32'd0);
        check("idle valid no match", match_found, 1'b0);
        check("idle valid no mesg", match_mesg, 152'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md5_match_filter.md
Name: md5_match_filter

Overview:
Downstream stage of md5core. It consumes the per-cycle digest stream (a/b/c/d words plus the carried message) and compares each digest against a host-supplied target hash.
It latches the first matching 152-bit message, counts hashes examined, and reports FOUND or EXHAUSTED to the host-side controller.
A two-stage registered compare keeps the 128-bit equality off md5core's critical output path.

Parameters:
MSG_W, 152, message width carried alongside the digest (19-byte candidate)
CNT_W, 32, width of hash counter and count_limit

Ports:
clk  input  1  system clock (single clock domain)
reset_n  input  1  asynchronous, active-low reset
en  input  1  global enable; when low, pipeline, FSM and counter hold
start  input  1  one-cycle pulse; arms a new search
abort  input  1  one-cycle pulse; returns to IDLE
target_hash  input  128  digest sought; [127:96]=A, [95:64]=B, [63:32]=C, [31:0]=D
count_limit  input  CNT_W  hashes to examine before giving up; 0 = unlimited
a_in, b_in, c_in, d_in  input  32 each  digest words from md5core
m_in  input  MSG_W  message associated with the digest
valid_in  input  1  digest/message valid this cycle
busy  output  1  high in SEARCH
done  output  1  high in FOUND or EXHAUSTED
match_found  output  1  high in FOUND
match_mesg  output  MSG_W  latched matching message
hash_count  output  CNT_W  valid digests examined in current search

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=done=match_found=0; match_mesg=0; hash_count=0; all pipeline valids=0.
- All registers advance only when en=1. With en=0, everything holds, including in-flight pipeline data.
- Stage 1, registered at edge N when valid_in=1:
  - eq[3] = (a_in==target_hash[127:96]), eq[2] = B, eq[1] = C, eq[0] = D.
  - m_in captured into mesg_s1; valid_s1 = valid_in.
- Stage 2, registered at edge N+1: hit = valid_s1 & (&eq). FSM and counter act on valid_s1 and hit.
  - Result latency from valid_in sample to match_found/done visible = 2 cycles.
- target_hash must be stable from start until done; changing it mid-search is undefined.
- FSM states:
  - IDLE:
    - start → SEARCH; clear hash_count, match_found and match_mesg in that same edge.
  - SEARCH:
    - On valid_s1: hash_count += 1, saturating at all-ones.
    - If hit → FOUND; match_mesg <= mesg_s1.
    - Else if count_limit!=0 and hash_count+1 == count_limit → EXHAUSTED.
    - If a result both matches and reaches the limit, FOUND wins, and hash_count still increments.
  - FOUND / EXHAUSTED:
    - Outputs hold.
    - Later pipeline results are ignored and not counted.
    - start → SEARCH with clear (restart).
- abort takes priority over start and over a same-cycle hit. It forces IDLE, clears busy and done, and keeps hash_count and match_mesg for readback.
- start while in SEARCH is ignored.
- valid_in while in IDLE still flows through stage 1, but stage 2 discards it: no count, no match.
- Data already in stage 1 at the start edge belongs to the new search if valid_s1 is set on the next edge. The bench must tolerate this 1-result overlap or idle the stream before start.
- busy = (state==SEARCH); done = (state==FOUND | state==EXHAUSTED); match_found = (state==FOUND). All are registered-state decodes, glitch-free.
- Reset asserted mid-search: immediate clear to reset values; no partial result retained.

Decomposition:
- Package md5_pkg holds:
  - MSG_W and HASH_W=128 constants.
  - A state enum {IDLE, SEARCH, FOUND, EXHAUSTED} as a 2-bit encoding.
  - A helper localparam for the word slices of target_hash, shared with md5core benches.
- One sub-module is natural: md5_hash_cmp. It is the two-stage compare pipeline, taking clk, reset_n, en, target, digest, message and valid, and producing hit, mesg_s1 and valid_s1.
- The FSM, counter and output latches stay in md5_match_filter.

Test Plan:
1. Reset, start with target=a2004f37_730b9445_670a738f_a0fc9ee5, limit=0. Drive 3 valids: non-match, then that digest with m="The quick brown fox" (54686520…666f78), then non-match. Expect match_found=1 two cycles after the 2nd valid, match_mesg=54686520_71756963_6b206272_6f776e20_666f78, hash_count=2, 3rd ignored.
2. limit=5, five non-matching digests → done=1, match_found=0, state EXHAUSTED, hash_count=5, two cycles after the 5th valid.
3. limit=3, third digest matches target → FOUND (match wins), hash_count=3.
4. Digest with only A,B,C equal (D=a0fc9ee4) → no match; hash_count increments; busy stays 1.
5. en=0 for 4 cycles between a matching valid_in and its decision → match_found delayed exactly 4 cycles. Then abort in FOUND → IDLE, done=0, match_mesg retained.
6. Assert reset_n=0 asynchronously mid-SEARCH, away from a clock edge → all outputs 0 immediately. After release, valid_in in IDLE is not counted (hash_count=0).
